// File: rtl/sd_serdes_pkg.sv
// Shared definitions for the serializer and the future deserializer.
//   sd_num_seg  : number of SER-bit segments needed to carry a PARA-bit word
//   ser_state_t : two-state word-level FSM encoding
package sd_serdes_pkg;

  typedef enum logic {SER_EMPTY, SER_BUSY} ser_state_t;

  function automatic int sd_num_seg(input int para, input int ser);
    return (para + ser - 1) / ser;
  endfunction

endpackage

// File: rtl/sd_seg_sel.sv
// Combinational segment selector: picks segment i_idx out of a packed hold
// word made of NUM_SEG segments of SER_WIDTH bits each.
//   i_hold : NUM_SEG*SER_WIDTH-bit packed word, segment 0 in the LSBs
//   i_idx  : segment index (caller keeps it below NUM_SEG)
//   o_seg  : selected SER_WIDTH-bit segment
module sd_seg_sel #(
  parameter int SER_WIDTH = 8,
  parameter int NUM_SEG   = 8,
  parameter int SEG_SZ    = 3
) (
  input  logic [NUM_SEG*SER_WIDTH-1:0] i_hold,
  input  logic [SEG_SZ-1:0]            i_idx,
  output logic [SER_WIDTH-1:0]         o_seg
);

  localparam int HOLD_W = NUM_SEG * SER_WIDTH;
  // Shift amount must reach HOLD_W-SER_WIDTH without overflow.
  localparam int SH_W   = $clog2(HOLD_W + 1);

  logic [SH_W-1:0]   w_shamt;
  logic [HOLD_W-1:0] w_shifted;

  assign w_shamt   = SH_W'(i_idx) * SH_W'(SER_WIDTH);
  assign w_shifted = i_hold >> w_shamt;
  assign o_seg     = w_shifted[SER_WIDTH-1:0];

endmodule

// File: rtl/sd_serializer_reg.sv
// Registered serializer: captures one parallel word and emits it as
// hold_ms+1 segments on an srdy/drdy stream, LSB- or MSB-segment first.
// Only p_drdy -> c_drdy is combinational; all p_* outputs come from registers.
//   clk, reset             : clock, synchronous active-high reset
//   c_data/c_ms_seg        : parallel word and index of its top valid segment
//   c_srdy/c_drdy          : producer handshake
//   p_data/p_seg/p_ef      : current segment, its index, last-segment flag
//   p_srdy/p_drdy          : consumer handshake
//
// state     | meaning
// SER_EMPTY | no word held, ready to accept
// SER_BUSY  | word held, presenting segment cnt (in send order)
module sd_serializer_reg
  import sd_serdes_pkg::*;
#(
  parameter int PARA_WIDTH = 63,
  parameter int SER_WIDTH  = 8,
  parameter int NUM_SEG    = sd_num_seg(PARA_WIDTH, SER_WIDTH),
  parameter int SEG_SZ     = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PARA_WIDTH-1:0] c_data,
  input  logic [SEG_SZ-1:0]     c_ms_seg,
  input  logic                  c_srdy,
  output logic                  c_drdy,
  output logic [SER_WIDTH-1:0]  p_data,
  output logic [SEG_SZ-1:0]     p_seg,
  output logic                  p_ef,
  output logic                  p_srdy,
  input  logic                  p_drdy
);

  localparam int                HOLD_W = NUM_SEG * SER_WIDTH;
  localparam logic [SEG_SZ-1:0] MS_MAX = SEG_SZ'(NUM_SEG - 1);

  ser_state_t          r_state, w_state_nxt;
  logic [HOLD_W-1:0]   r_hold;
  logic [SEG_SZ-1:0]   r_hold_ms;
  logic [SEG_SZ-1:0]   r_cnt;

  logic                w_busy;
  logic                w_last;
  logic                w_word_done;
  logic                w_load;
  logic                w_adv;
  logic [SEG_SZ-1:0]   w_idx;
  logic [SEG_SZ-1:0]   w_ms_clamp;
  logic [SER_WIDTH-1:0] w_seg;

  sd_seg_sel #(
    .SER_WIDTH (SER_WIDTH),
    .NUM_SEG   (NUM_SEG),
    .SEG_SZ    (SEG_SZ)
  ) u_seg_sel (
    .i_hold (r_hold),
    .i_idx  (w_idx),
    .o_seg  (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= SER_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state == SER_BUSY);
    w_last      = (r_cnt == r_hold_ms);
    w_word_done = w_busy && w_last && p_drdy;
    c_drdy      = !reset && (!w_busy || w_word_done);
    w_load      = c_srdy && c_drdy;
    w_adv       = w_busy && p_drdy && !w_last;
    w_ms_clamp  = (c_ms_seg > MS_MAX) ? MS_MAX : c_ms_seg;
    // MSB-first walks down from hold_ms; cnt <= hold_ms so no wrap.
    w_idx       = MSB_FIRST ? (r_hold_ms - r_cnt) : r_cnt;

    p_srdy = w_busy;
    p_data = '0;
    p_seg  = '0;
    p_ef   = 1'b0;
    if (w_busy) begin
      p_data = w_seg;
      p_seg  = w_idx;
      p_ef   = w_last;
    end

    case (r_state)
      SER_EMPTY: if (w_load) w_state_nxt = SER_BUSY;
      SER_BUSY:  if (w_word_done && !w_load) w_state_nxt = SER_EMPTY;
      default:   w_state_nxt = SER_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold    <= '0;
      r_hold_ms <= '0;
      r_cnt     <= '0;
    end else if (w_load) begin
      r_hold    <= HOLD_W'(c_data);
      r_hold_ms <= w_ms_clamp;
      r_cnt     <= '0;
    end else if (w_adv) begin
      r_cnt     <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_serializer_reg.sv
module tb_sd_serializer_reg;

  localparam int PW = 20;
  localparam int SW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] c_data = '0;
  logic [SS-1:0] c_ms_seg = '0;
  logic          c_srdy = 1'b0;
  logic          p_drdy = 1'b0;

  logic          c_drdy_l, p_ef_l, p_srdy_l;
  logic [SW-1:0] p_data_l;
  logic [SS-1:0] p_seg_l;
  logic          c_drdy_m, p_ef_m, p_srdy_m;
  logic [SW-1:0] p_data_m;
  logic [SS-1:0] p_seg_m;

  sd_serializer_reg #(.PARA_WIDTH(PW), .SER_WIDTH(SW), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .c_data(c_data), .c_ms_seg(c_ms_seg),
    .c_srdy(c_srdy), .c_drdy(c_drdy_l), .p_data(p_data_l), .p_seg(p_seg_l),
    .p_ef(p_ef_l), .p_srdy(p_srdy_l), .p_drdy(p_drdy));

  sd_serializer_reg #(.PARA_WIDTH(PW), .SER_WIDTH(SW), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .c_data(c_data), .c_ms_seg(c_ms_seg),
    .c_srdy(c_srdy), .c_drdy(c_drdy_m), .p_data(p_data_m), .p_seg(p_seg_m),
    .p_ef(p_ef_m), .p_srdy(p_srdy_m), .p_drdy(p_drdy));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
    logic       ef;
  } seg_t;

  typedef struct {
    logic [19:0] data;
    logic [1:0]  ms;
    logic [7:0]  e0, e1, e2;
    int          n;
  } vec_t;

  seg_t q_l[$];
  seg_t q_m[$];
  logic [7:0] cur_e [3];
  int   cur_n;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word();
    seg_t e;
    for (int i = 0; i < cur_n; i++) begin
      e.d = cur_e[i]; e.s = 2'(i); e.ef = (i == cur_n - 1);
      q_l.push_back(e);
      e.d = cur_e[cur_n-1-i]; e.s = 2'(cur_n-1-i); e.ef = (i == cur_n - 1);
      q_m.push_back(e);
    end
  endtask

  // Called #1 after a posedge with inputs already driven; returns at the
  // same phase of the next cycle.
  task automatic step(output bit acc);
    bit exp_cd;
    bit pop;
    exp_cd = 1'b0;
    @(negedge clk);
    if (reset) begin
      chk("c_drdy_in_reset_lsb", c_drdy_l, 0);
      chk("c_drdy_in_reset_msb", c_drdy_m, 0);
    end else begin
      exp_cd = (q_l.size() == 0) || (q_l[0].ef && p_drdy);
      chk("c_drdy_lsb", c_drdy_l, exp_cd);
      chk("c_drdy_msb", c_drdy_m, exp_cd);
      chk("p_srdy_lsb", p_srdy_l, q_l.size() != 0);
      chk("p_srdy_msb", p_srdy_m, q_m.size() != 0);
      if (q_l.size() != 0) begin
        chk("p_data_lsb", p_data_l, q_l[0].d);
        chk("p_seg_lsb",  p_seg_l,  q_l[0].s);
        chk("p_ef_lsb",   p_ef_l,   q_l[0].ef);
        chk("p_data_msb", p_data_m, q_m[0].d);
        chk("p_seg_msb",  p_seg_m,  q_m[0].s);
        chk("p_ef_msb",   p_ef_m,   q_m[0].ef);
      end
    end
    pop = !reset && (q_l.size() != 0) && p_drdy;
    acc = !reset && c_srdy && exp_cd;
    @(posedge clk);
    if (reset) begin
      q_l.delete();
      q_m.delete();
    end else begin
      if (pop) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (acc) push_word();
    end
    #1;
  endtask

  task automatic send(input logic [19:0] d, input logic [1:0] ms,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input int n, input bit rnd);
    bit acc;
    bit done;
    cur_e[0] = e0; cur_e[1] = e1; cur_e[2] = e2; cur_n = n;
    c_data = d; c_ms_seg = ms; c_srdy = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rnd) p_drdy = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) done = 1'b1;
    end
    chk("accept_timeout", {31'd0, done}, 1);
    c_srdy = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    bit acc;
    for (int i = 0; i < 200 && q_l.size() != 0; i++) begin
      if (rnd) p_drdy = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    chk("drain_timeout", q_l.size(), 0);
    p_drdy = 1'b1;
    step(acc);
  endtask

  vec_t vecs[3];

  initial begin
    bit acc;
    logic [19:0] rd;
    logic [1:0]  rms;
    int          rn;

    vecs[0] = '{20'hABCDE, 2'd2, 8'hDE, 8'hBC, 8'h0A, 3};
    vecs[1] = '{20'hABCDE, 2'd3, 8'hDE, 8'hBC, 8'h0A, 3};
    vecs[2] = '{20'h0F0F7, 2'd1, 8'hF7, 8'hF0, 8'h00, 2};

    reset = 1'b1;
    p_drdy = 1'b1;
    step(acc);
    step(acc);
    @(negedge clk);
    chk("rst_p_srdy", {p_srdy_l, p_srdy_m}, 0);
    chk("rst_p_ef",   {p_ef_l, p_ef_m}, 0);
    chk("rst_p_seg",  {p_seg_l, p_seg_m}, 0);
    chk("rst_p_data", {p_data_l, p_data_m}, 0);
    chk("rst_c_drdy", {c_drdy_l, c_drdy_m}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(acc);

    for (int v = 0; v < 3; v++) begin
      send(vecs[v].data, vecs[v].ms, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].n, 1'b0);
      drain(1'b0);
    end

    // back-to-back single and two-segment words
    send(20'h11111, 2'd0, 8'h11, 8'h00, 8'h00, 1, 1'b0);
    send(20'h22222, 2'd1, 8'h22, 8'h22, 8'h00, 2, 1'b0);
    send(20'h33333, 2'd0, 8'h33, 8'h00, 8'h00, 1, 1'b0);
    drain(1'b0);

    // random stalls, random ms (3 exercises clamping)
    for (int w = 0; w < 200; w++) begin
      if ($urandom_range(0, 3) == 0) begin
        p_drdy = ($urandom_range(0, 1) != 0);
        step(acc);
      end
      rd  = 20'($urandom);
      rms = 2'($urandom_range(0, 3));
      rn  = (rms >= 2) ? 3 : int'(rms) + 1;
      send(rd, rms, rd[7:0], rd[15:8], {4'h0, rd[19:16]}, rn, 1'b1);
    end
    drain(1'b1);

    // reset in BUSY after the first segment transferred
    p_drdy = 1'b1;
    send(20'hABCDE, 2'd2, 8'hDE, 8'hBC, 8'h0A, 3, 1'b0);
    step(acc);
    reset = 1'b1;
    step(acc);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_p_srdy", {p_srdy_l, p_srdy_m}, 0);
    @(posedge clk);
    #1;
    send(20'h12345, 2'd2, 8'h45, 8'h23, 8'h01, 3, 1'b0);
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_serializer_reg.md
# sd_serializer_reg

Registered, parametrised successor to the combinational serializer. It captures one PARA_WIDTH parallel word, then emits it as up to NUM_SEG SER_WIDTH-bit segments on an srdy/drdy stream. Segment order is selectable (LSB-first or MSB-first), and no combinational path exists from the consumer port to the producer port. It sits between wide datapath FIFOs and narrow link/serdes channels, where timing isolation and full-rate back-to-back words are required.

## Interface
- PARA_WIDTH, 63, parallel word width.
- SER_WIDTH, 8, segment width.
- NUM_SEG, ceil(PARA_WIDTH/SER_WIDTH), segment count; the last segment is zero-padded above PARA_WIDTH.
- SEG_SZ, max(1,$clog2(NUM_SEG)), segment index width.
- MSB_FIRST, 0; 0 sends seg 0..ms, 1 sends seg ms..0.
- clk  in  1  clock; the block uses one clock.
- reset  in  1  synchronous, active-high reset.
- c_data  in  PARA_WIDTH  parallel word.
- c_ms_seg  in  SEG_SZ  index of the most-significant valid segment; values above NUM_SEG-1 are clamped to NUM_SEG-1.
- c_srdy  in  1  producer valid.
- c_drdy  out  1  block can accept a word.
- p_data  out  SER_WIDTH  current segment.
- p_seg  out  SEG_SZ  index of the current segment within the word.
- p_ef  out  1  end-of-frame; the current segment is the last of the word.
- p_srdy  out  1  segment valid.
- p_drdy  in  1  consumer ready.

## Operation
- Storage: hold register of NUM_SEG*SER_WIDTH bits (zero-extended c_data), hold_ms (clamped c_ms_seg), and counter cnt.
- States: EMPTY and BUSY.
- EMPTY: c_drdy=1, p_srdy=0. On c_srdy, load hold, load hold_ms, set cnt=0, go to BUSY.
- BUSY: p_srdy=1.
  - Segment index: idx = cnt when MSB_FIRST=0; idx = hold_ms-cnt when MSB_FIRST=1.
  - p_data = hold[idx*SER_WIDTH +: SER_WIDTH]; p_seg = idx.
  - p_ef = (cnt==hold_ms).
- On p_drdy with !p_ef: cnt increments.
- On p_drdy with p_ef: the word is done. c_drdy=1 in this cycle.
  - If c_srdy is also high, load the new word, set cnt=0, and stay in BUSY with no bubble.
  - Otherwise go to EMPTY.
- c_drdy = !reset && (state==EMPTY || (p_srdy && p_ef && p_drdy)). This is the only combinational path, and it runs from p_drdy to c_drdy. c_drdy never depends on c_srdy.
- p_data, p_seg, p_ef and p_srdy depend only on registers.
- Single-segment word (hold_ms=0): p_ef=1 on its only segment.
- If p_drdy is low, all outputs hold stable and cnt does not move.
- Arithmetic: cnt is SEG_SZ bits and never exceeds hold_ms, so it never wraps. idx is computed in SEG_SZ bits. The shift uses an index width sufficient for NUM_SEG*SER_WIDTH.

## Timing
- Reset values: state=EMPTY, p_srdy=0, p_ef=0, cnt=0, p_seg=0, p_data=0. c_drdy=0 while reset is high, and 1 in the first cycle after reset.
- Reset while in BUSY discards the held word. No partial segment appears after reset.
- Latency: a word accepted at edge N shows its first segment at cycle N+1.
- Throughput: a word with ms=k occupies k+1 cycles when p_drdy is held high. Back-to-back words produce one segment every cycle.
- A segment transfers on a clk edge with p_srdy && p_drdy. A word transfers on an edge with c_srdy && c_drdy.

## Structure
- Package sd_serdes_pkg holds:
  - function sd_num_seg(para, ser), which returns the NUM_SEG ceiling;
  - typedef enum logic {SER_EMPTY, SER_BUSY} ser_state_t.
  - A future deserializer shares this package.
- Sub-module sd_seg_sel: purely combinational; takes hold, idx and the parameters and returns the segment. It is reusable by the deserializer bench model.
- The top level holds the FSM, counter and hold registers.

## Test plan
All scenarios use PARA_WIDTH=20, SER_WIDTH=8, so NUM_SEG=3.
- Word 0xABCDE, ms=2, MSB_FIRST=0, p_drdy=1:
  - p_data is 0xDE, 0xBC, 0x0A on cycles N+1..N+3;
  - p_seg is 0,1,2;
  - p_ef is high only on 0x0A;
  - c_drdy=1 on cycle N+3.
- Same word with MSB_FIRST=1: p_data is 0x0A, 0xBC, 0xDE; p_seg is 2,1,0; p_ef is on 0xDE.
- Words 0x11111 (ms=0) and 0x22222 (ms=1) presented back to back:
  - 0x11 has p_ef=1;
  - the next cycle shows 0x22, then 0x22 with p_ef;
  - p_srdy has no low cycle between the words.
- c_ms_seg=3 (out of range) with word 0xABCDE: the output is clamped to 3 segments, identical to ms=2.
- Random p_drdy stalls over 200 words of random ms: a scoreboard checks segment order, p_ef placement, and that outputs stay stable during stalls.
- Reset asserted in BUSY after the first segment of 0xABCDE: p_srdy=0 on the next cycle; the next accepted word 0x12345 starts at segment 0 (0x45).
